pkt_injector: RTL and testbench
===============================

PKT_INJECTOR -- requirements
Module: pkt_injector

Interface
REQ-001 Parameter FLIT_WIDTH, default 32, flit and data_o width.
REQ-002 Parameter MEMORY_BUS_WIDTH, default 32, mem_data_i width; SHALL equal FLIT_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 16, word-address width of mem_addr_o and src_addr_i.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start_i  in  1  request one packet; sampled only in IDLE.
REQ-007 dest_i  in  FLIT_WIDTH  header flit value, (x << FLIT_WIDTH/4) | y.
REQ-008 len_i  in  16  payload flit count, 0..65535.
REQ-009 src_addr_i  in  ADDR_WIDTH  word address of the first payload word.
REQ-010 busy_o  out  1  high from the cycle after start acceptance until done_o.
REQ-011 done_o  out  1  one-cycle pulse after the last flit transfer.
REQ-012 mem_en_o  out  1  memory read strobe.
REQ-013 mem_addr_o  out  ADDR_WIDTH  read word address.
REQ-014 mem_data_i  in  MEMORY_BUS_WIDTH  read data, valid exactly 1 cycle after mem_en_o.
REQ-015 tx_o  out  1  flit valid toward router LOCAL port.
REQ-016 data_o  out  FLIT_WIDTH  flit.
REQ-017 credit_i  in  1  router LOCAL buffer has space.
REQ-018 clock_tx_o  out  1  equals clock.

Function
REQ-019 Transfer occurs on a rising edge with tx_o=1 and credit_i=1; no other condition moves a flit.
REQ-020 While tx_o=1 and credit_i=0, data_o SHALL hold stable and tx_o SHALL stay high.
REQ-021 FSM states: IDLE, HEADER, SIZE, PAYLOAD, DONE.
REQ-022 IDLE: start_i=1 latches dest_i, len_i, src_addr_i; next HEADER. start_i in any other state is ignored.
REQ-023 HEADER: tx_o=1, data_o=latched dest; transfer -> SIZE.
REQ-024 SIZE: tx_o=1, data_o=len zero-extended to FLIT_WIDTH; transfer -> PAYLOAD if len>0, else DONE.
REQ-025 PAYLOAD: flits come from a 2-entry prefetch FIFO; tx_o=1 iff FIFO not empty; data_o=FIFO head.
REQ-026 Prefetch starts on entry to HEADER; mem_en_o asserts when reads-remaining>0 and FIFO occupancy plus in-flight reads <2.
REQ-027 mem_addr_o starts at src_addr_i, increments by 1 per read, wraps modulo 2^ADDR_WIDTH.
REQ-028 Read data enters FIFO on the cycle after mem_en_o; simultaneous push and pop keep occupancy constant; no word lost or duplicated.
REQ-029 Exactly len reads per packet; 16-bit send counter; PAYLOAD -> DONE on transfer of the len-th payload flit.
REQ-030 DONE: done_o=1 for one cycle, tx_o=0; next IDLE; new start accepted from that IDLE cycle.
REQ-031 With credit_i constantly 1 and len=N>0, flits issue back to back: N+2 consecutive transfer cycles.
REQ-032 busy_o=1 in HEADER, SIZE, PAYLOAD, DONE.

Reset
REQ-033 reset=1 at an edge: state IDLE, FIFO empty, counters 0, in-flight read discarded.
REQ-034 Reset values: busy_o=0, done_o=0, mem_en_o=0, mem_addr_o=0, tx_o=0, data_o=0.
REQ-035 Reset mid-packet aborts it: tx_o=0 the next cycle, no done_o, remaining flits never sent.

Verification
REQ-036 credit_i=1, dest=0x0101, len=3, src=0x0010, mem[k]=0xA0+k -> data_o 0x101, 3, 0xB0, 0xB1, 0xB2 on 5 consecutive edges; done_o the next cycle.
REQ-037 len=0, dest=0x0001 -> flits 0x1, 0x0; zero mem_en_o; done_o.
REQ-038 len=4, credit_i toggles 1,0,0,1,... -> data_o stable while stalled; exactly 6 transfers in order; FIFO never >2.
REQ-039 src=0xFFFF, len=3 (ADDR_WIDTH=16) -> reads 0xFFFF, 0x0000, 0x0001.
REQ-040 start_i pulsed mid-packet -> ignored; reset asserted after 2nd payload flit -> tx_o=0 next cycle, no done_o, next start sends a full packet.

Source files
------------

// File: rtl/pkt_injector.sv
// Packet injector: streams a header flit, a length flit and a memory-sourced
// payload toward a router LOCAL port, under credit flow control.
module pkt_injector #(
    parameter int unsigned FLIT_WIDTH       = 32,
    parameter int unsigned MEMORY_BUS_WIDTH = 32,  // must equal FLIT_WIDTH
    parameter int unsigned ADDR_WIDTH       = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [FLIT_WIDTH-1:0]       dest_i,
    input  logic [15:0]                 len_i,
    input  logic [ADDR_WIDTH-1:0]       src_addr_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        mem_en_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_i,
    output logic                        tx_o,
    output logic [FLIT_WIDTH-1:0]       data_o,
    input  logic                        credit_i,
    output logic                        clock_tx_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StSize,
        StPayload,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [FLIT_WIDTH-1:0]   dest_q;
    logic [15:0]             len_q;
    logic [15:0]             reads_left_q;
    logic [15:0]             sent_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    inflight_q;

    // Two-entry prefetch FIFO
    logic [FLIT_WIDTH-1:0]   fifo_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;

    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    prefetch_active;
    logic                    accept;
    logic [1:0]              occ_after_pop;

    assign clock_tx_o = clock;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign mem_addr_o = addr_q;

    assign fifo_empty = (count_q == 2'd0);
    assign push       = inflight_q;
    assign pop        = (state_q == StPayload) && tx_o && credit_i;
    assign accept     = (state_q == StIdle) && start_i;

    assign prefetch_active = (state_q == StHeader) || (state_q == StSize) ||
                             (state_q == StPayload);

    // Counting the slot freed by this cycle's pop lets reads overlap with a
    // draining FIFO, which is what keeps payload flits back to back.
    assign occ_after_pop = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign mem_en_o      = prefetch_active && (reads_left_q != 16'd0) &&
                           (occ_after_pop < 2'd2);

    always_comb begin
        state_d = state_q;
        tx_o    = 1'b0;
        data_o  = '0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StHeader;
                end
            end
            StHeader: begin
                tx_o   = 1'b1;
                data_o = dest_q;
                if (credit_i) begin
                    state_d = StSize;
                end
            end
            StSize: begin
                tx_o   = 1'b1;
                data_o = FLIT_WIDTH'(len_q);
                if (credit_i) begin
                    state_d = (len_q != 16'd0) ? StPayload : StDone;
                end
            end
            StPayload: begin
                if (!fifo_empty) begin
                    tx_o   = 1'b1;
                    data_o = fifo_q[rd_ptr_q];
                    if (credit_i && (sent_q == len_q - 16'd1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            dest_q       <= '0;
            len_q        <= '0;
            reads_left_q <= '0;
            sent_q       <= '0;
            addr_q       <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= mem_en_o;
            if (accept) begin
                dest_q       <= dest_i;
                len_q        <= len_i;
                reads_left_q <= len_i;
                addr_q       <= src_addr_i;
                sent_q       <= '0;
            end else begin
                if (mem_en_o) begin
                    addr_q       <= addr_q + ADDR_WIDTH'(1);
                    reads_left_q <= reads_left_q - 16'd1;
                end
                if (pop) begin
                    sent_q <= sent_q + 16'd1;
                end
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= FLIT_WIDTH'(mem_data_i);
        end
    end

endmodule

// File: tb/tb_pkt_injector.sv
// Scoreboard bench for pkt_injector: expected flits and read addresses are
// queued when a packet is requested and retired as the DUT produces them.
module tb_pkt_injector;

    localparam int unsigned FW = 32;
    localparam int unsigned AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic [FW-1:0] dest_i = '0;
    logic [15:0]   len_i = '0;
    logic [AW-1:0] src_addr_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [FW-1:0] mem_data_i = 32'hDEAD_BEEF;
    logic          tx_o;
    logic [FW-1:0] data_o;
    logic          credit_i = 1'b1;
    logic          clock_tx_o;

    pkt_injector #(
        .FLIT_WIDTH      (FW),
        .MEMORY_BUS_WIDTH(FW),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start_i   (start_i),
        .dest_i    (dest_i),
        .len_i     (len_i),
        .src_addr_i(src_addr_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .mem_en_o  (mem_en_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_i(mem_data_i),
        .tx_o      (tx_o),
        .data_o    (data_o),
        .credit_i  (credit_i),
        .clock_tx_o(clock_tx_o)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_flits[$];
    logic [AW-1:0] exp_addrs[$];

    int cyc = 0;
    int xfers_total = 0;
    int reads_total = 0;
    int pops_total = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int flit_idx = 0;
    int max_occ = 0;
    bit prev_stall = 1'b0;
    bit prev_done = 1'b0;
    logic [FW-1:0] prev_data = '0;
    logic [63:0] ea_mon;
    logic [63:0] ef_mon;

    int credit_mode = 0;  // 0: always 1, 1: 1,0,0 repeating, 2: always 0, 3: random
    int phase = 0;

    function automatic logic [FW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA0 + 32'(a);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Synchronous-read memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clock) begin
        mem_data_i <= mem_en_o ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;
    end

    always @(posedge clock) begin
        #2;
        phase = (phase == 2) ? 0 : phase + 1;
        case (credit_mode)
            0:       credit_i = 1'b1;
            1:       credit_i = (phase == 0);
            2:       credit_i = 1'b0;
            default: credit_i = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            prev_stall  = 1'b0;
            prev_done   = 1'b0;
            flit_idx    = 0;
            reads_total = pops_total;
        end else begin
            if (reads_total - pops_total > max_occ) max_occ = reads_total - pops_total;
            if (prev_stall) begin
                check_eq("stall_tx", 64'(tx_o), 64'd1);
                check_eq("stall_data", 64'(data_o), 64'(prev_data));
            end
            if (mem_en_o) begin
                ea_mon = '1;
                if (exp_addrs.size() != 0) ea_mon = 64'(exp_addrs.pop_front());
                check_eq("read_addr", 64'(mem_addr_o), ea_mon);
                reads_total++;
            end
            if (tx_o && credit_i) begin
                ef_mon = '1;
                if (exp_flits.size() != 0) ef_mon = exp_flits.pop_front();
                check_eq("flit", 64'(data_o), ef_mon);
                if (flit_idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (flit_idx >= 2) pops_total++;
                flit_idx++;
                xfers_total++;
            end
            if (done_o) begin
                check_eq("done_tx", 64'(tx_o), 64'd0);
                check_eq("done_pulse", 64'(prev_done), 64'd0);
                done_cnt++;
                done_cyc = cyc;
                flit_idx = 0;
            end
            prev_stall = tx_o && !credit_i;
            prev_data  = data_o;
            prev_done  = done_o;
        end
    end

    task automatic drive_start(input logic [31:0] dest, input logic [15:0] len,
                               input logic [15:0] src);
        logic [AW-1:0] a;
        @(posedge clock);
        #1;
        start_i    = 1'b1;
        dest_i     = dest;
        len_i      = len;
        src_addr_i = src;
        exp_flits.push_back(64'(dest));
        exp_flits.push_back(64'(len));
        for (int k = 0; k < int'(len); k++) begin
            a = src + 16'(k);
            exp_flits.push_back(64'(mem_word(a)));
            exp_addrs.push_back(a);
        end
        @(posedge clock);
        #1;
        start_i = 1'b0;
        dest_i  = '0;
        len_i   = '0;
    endtask

    task automatic send_pkt(input logic [31:0] dest, input logic [15:0] len,
                            input logic [15:0] src, input bit mid_start);
        int d0;
        int x0;
        int r0;
        d0 = done_cnt;
        x0 = xfers_total;
        r0 = reads_total;
        drive_start(dest, len, src);
        if (mid_start) begin
            repeat (3) @(posedge clock);
            #1;
            start_i    = 1'b1;
            dest_i     = 32'h0707;
            len_i      = 16'd7;
            src_addr_i = 16'h2000;
            @(posedge clock);
            #1;
            start_i = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(posedge clock);
        check_eq("done_seen", 64'(done_cnt), 64'(d0 + 1));
        check_eq("xfer_count", 64'(xfers_total - x0), 64'(int'(len) + 2));
        check_eq("read_count", 64'(reads_total - r0), 64'(len));
        check_eq("flits_left", 64'(exp_flits.size()), 64'd0);
        check_eq("addrs_left", 64'(exp_addrs.size()), 64'd0);
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_mem_en", 64'(mem_en_o), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check_eq("rst_tx", 64'(tx_o), 64'd0);
        check_eq("rst_data", 64'(data_o), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic packet, full credit: five consecutive transfers, then done.
        credit_mode = 0;
        send_pkt(32'h0101, 16'd3, 16'h0010, 1'b0);
        check_eq("b2b_span3", 64'(last_cyc - first_cyc), 64'd4);
        check_eq("done_after_last", 64'(done_cyc - last_cyc), 64'd1);

        // Zero-length packet: header and size only, no reads.
        send_pkt(32'h0001, 16'd0, 16'h0300, 1'b0);

        // Throttled credit with a stray start mid-packet.
        credit_mode = 1;
        send_pkt(32'h0203, 16'd4, 16'h0040, 1'b1);
        credit_mode = 0;
        repeat (3) @(negedge clock);
        check_eq("stray_start_idle", 64'(busy_o), 64'd0);

        // Address wrap.
        send_pkt(32'h0302, 16'd3, 16'hFFFF, 1'b0);

        // Longer back-to-back packet.
        send_pkt(32'h0404, 16'd8, 16'h0100, 1'b0);
        check_eq("b2b_span8", 64'(last_cyc - first_cyc), 64'd9);

        // Reset after the second payload flit aborts the packet.
        d0 = done_cnt;
        drive_start(32'h0505, 16'd4, 16'h0200);
        for (int i = 0; i < 100 && flit_idx < 4; i++) @(posedge clock);
        check_eq("abort_reach", 64'(flit_idx), 64'd4);
        #1;
        reset       = 1'b1;
        credit_mode = 2;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_flits.delete();
        exp_addrs.delete();
        credit_mode = 0;
        @(negedge clock);
        check_eq("abort_tx", 64'(tx_o), 64'd0);
        check_eq("abort_busy", 64'(busy_o), 64'd0);
        repeat (5) @(posedge clock);
        check_eq("abort_no_done", 64'(done_cnt), 64'(d0));
        send_pkt(32'h0505, 16'd4, 16'h0200, 1'b0);

        // Random credit, assorted packets.
        credit_mode = 3;
        for (int p = 0; p < 4; p++) begin
            send_pkt($urandom, 16'($urandom_range(0, 6)), 16'($urandom), 1'b0);
        end
        credit_mode = 0;

        check_eq("fifo_bound", 64'(max_occ > 2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
